// File: rtl/prt_slot_buffer.sv
// prt_slot_buffer: multi-slot packet reference table.
// Frames arrive on a valid/ready ingress stream, are stored in the lowest free
// slot, and are replayed on a valid/ready egress stream when a slot is requested.
// Optional feature macro: PRT_INVALIDATE_EN adds inv_valid/inv_slot/inv_err, so a
// complete frame can be dropped without being transmitted.
//
// Handshake rule for both streams: a beat transfers on a rising edge where valid
// and ready are both 1. The side holding valid keeps data/last stable until then.

module prt_slot_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLOTS  = 4,
    parameter int MAX_BEATS  = 1518,
    localparam int SLOT_W    = $clog2(NUM_SLOTS),
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_start,
    output logic                  wr_start_ack,
    output logic [SLOT_W-1:0]     wr_slot_id,
    input  logic                  wr_abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  wr_done,
    output logic                  wr_err,
    input  logic                  rd_req,
    input  logic [SLOT_W-1:0]     rd_slot,
    output logic                  rd_ack,
    output logic                  rd_rej,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
`ifdef PRT_INVALIDATE_EN
    input  logic                  inv_valid,
    input  logic [SLOT_W-1:0]     inv_slot,
    output logic                  inv_err,
`endif
    output logic [SLOT_W:0]       free_count,
    output logic                  slot_available,
    output logic [NUM_SLOTS-1:0]  complete_mask
);

    localparam int DEPTH  = NUM_SLOTS * MAX_BEATS;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_FREE, S_FILLING, S_COMPLETE, S_SENDING} slot_st_t;
    typedef enum logic [1:0] {WR_IDLE, WR_RECV, WR_DROP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

    // Slot bookkeeping and frame storage (slot i owns beats i*MAX_BEATS ..)
    slot_st_t              slot_st  [NUM_SLOTS];
    slot_st_t              slot_nxt [NUM_SLOTS];
    logic [CNT_W-1:0]      beat_cnt [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] mem      [DEPTH];

    // FSM state, kept as named signals so checkers can bind to them
    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic                  free_any;
    logic [SLOT_W-1:0]     free_idx;
    logic                  alloc_fire, beat_store, wr_fin, wr_ovf, wr_kill;
    logic                  rd_accept, rd_refuse, rd_load, rd_adv, rd_finish, rd_ok;
    logic [SLOT_W-1:0]     rd_slot_q;
    logic [CNT_W-1:0]      rd_ptr, rd_ptr_nxt, rd_cnt, wr_cnt;
    logic [ADDR_W-1:0]     wr_addr, rd_base;
    logic                  inv_fire;
    logic [SLOT_W-1:0]     inv_idx;
    logic [SLOT_W:0]       free_cnt_nxt;
    logic [NUM_SLOTS-1:0]  cmask_nxt;

    assign wr_cnt     = beat_cnt[wr_slot_id];
    assign wr_addr    = ADDR_W'(wr_slot_id) * ADDR_W'(MAX_BEATS) + ADDR_W'(wr_cnt);
    assign rd_cnt     = beat_cnt[rd_slot_q];
    assign rd_base    = ADDR_W'(rd_slot_q) * ADDR_W'(MAX_BEATS);
    assign rd_ptr_nxt = rd_ptr + CNT_W'(1);

`ifdef PRT_INVALIDATE_EN
    assign inv_idx  = inv_slot;
    assign inv_fire = inv_valid && (slot_st[inv_slot] == S_COMPLETE);

    // Invalidate on a slot that is not COMPLETE is reported one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inv_err <= 1'b0;
        else        inv_err <= inv_valid && !inv_fire;
    end
`else
    assign inv_idx  = '0;
    assign inv_fire = 1'b0;
`endif

    // Lowest-index free slot, judged on the registered slot states only
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_st[i] == S_FREE) begin
                free_any = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    // Write FSM next state and per-cycle ingress events
    always_comb begin
        wr_state_nxt = wr_state;
        in_ready     = 1'b0;
        alloc_fire   = 1'b0;
        beat_store   = 1'b0;
        wr_fin       = 1'b0;
        wr_ovf       = 1'b0;
        wr_kill      = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (wr_start && free_any) begin
                    alloc_fire   = 1'b1;
                    wr_state_nxt = WR_RECV;
                end
            end
            WR_RECV: begin
                if (wr_abort) begin
                    wr_kill      = 1'b1;
                    wr_state_nxt = WR_IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        if (wr_cnt == CNT_W'(MAX_BEATS)) begin
                            wr_ovf       = 1'b1;
                            wr_state_nxt = in_last ? WR_IDLE : WR_DROP;
                        end else begin
                            beat_store = 1'b1;
                            if (in_last) begin
                                wr_fin       = 1'b1;
                                wr_state_nxt = WR_IDLE;
                            end
                        end
                    end
                end
            end
            WR_DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) wr_state_nxt = WR_IDLE;
            end
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    // Invalidate beats a read of the same slot in the same cycle
    assign rd_ok = (slot_st[rd_slot] == S_COMPLETE) && !(inv_fire && (inv_idx == rd_slot));

    // Read FSM next state and per-cycle egress events
    always_comb begin
        rd_state_nxt = rd_state;
        rd_accept    = 1'b0;
        rd_refuse    = 1'b0;
        rd_load      = 1'b0;
        rd_adv       = 1'b0;
        rd_finish    = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (rd_req) begin
                    if (rd_ok) begin
                        rd_accept    = 1'b1;
                        rd_state_nxt = RD_STREAM;
                    end else begin
                        rd_refuse = 1'b1;
                    end
                end
            end
            RD_STREAM: begin
                // out_valid low only in the rd_ack cycle: fetch beat 0 then
                if (!out_valid) begin
                    rd_load = 1'b1;
                end else if (out_ready) begin
                    if (out_last) begin
                        rd_finish    = 1'b1;
                        rd_state_nxt = RD_IDLE;
                    end else begin
                        rd_adv = 1'b1;
                    end
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    // Slot state after this edge; every event targets a distinct slot
    always_comb begin
        slot_nxt = slot_st;
        if (alloc_fire)       slot_nxt[free_idx]   = S_FILLING;
        if (wr_fin)           slot_nxt[wr_slot_id] = S_COMPLETE;
        if (wr_ovf || wr_kill) slot_nxt[wr_slot_id] = S_FREE;
        if (rd_accept)        slot_nxt[rd_slot]    = S_SENDING;
        if (rd_finish)        slot_nxt[rd_slot_q]  = S_FREE;
        if (inv_fire)         slot_nxt[inv_idx]    = S_FREE;
        free_cnt_nxt = '0;
        cmask_nxt    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_nxt[i] == S_FREE) free_cnt_nxt = free_cnt_nxt + (SLOT_W + 1)'(1);
            cmask_nxt[i] = (slot_nxt[i] == S_COMPLETE);
        end
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_state <= WR_IDLE;
        else        wr_state <= wr_state_nxt;
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state <= RD_IDLE;
        else        rd_state <= rd_state_nxt;
    end

    // Frame storage write port; contents need no reset
    always_ff @(posedge clk) begin
        if (beat_store) mem[wr_addr] <= in_data;
    end

    // Slot table, counters, status and registered pulses / egress outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_st[i]  <= S_FREE;
                beat_cnt[i] <= '0;
            end
            free_count    <= (SLOT_W + 1)'(NUM_SLOTS);
            complete_mask <= '0;
            wr_start_ack  <= 1'b0;
            wr_slot_id    <= '0;
            wr_done       <= 1'b0;
            wr_err        <= 1'b0;
            rd_ack        <= 1'b0;
            rd_rej        <= 1'b0;
            rd_slot_q     <= '0;
            rd_ptr        <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_data      <= '0;
        end else begin
            slot_st       <= slot_nxt;
            free_count    <= free_cnt_nxt;
            complete_mask <= cmask_nxt;
            wr_start_ack  <= alloc_fire;
            wr_done       <= wr_fin;
            wr_err        <= wr_ovf;
            rd_ack        <= rd_accept;
            rd_rej        <= rd_refuse;
            if (alloc_fire) begin
                wr_slot_id         <= free_idx;
                beat_cnt[free_idx] <= '0;
            end
            if (beat_store) beat_cnt[wr_slot_id] <= wr_cnt + CNT_W'(1);
            if (rd_accept)  rd_slot_q <= rd_slot;
            if (rd_load) begin
                out_valid <= 1'b1;
                out_data  <= mem[rd_base];
                out_last  <= (rd_cnt == CNT_W'(1));
                rd_ptr    <= '0;
            end
            if (rd_adv) begin
                rd_ptr   <= rd_ptr_nxt;
                out_data <= mem[rd_base + ADDR_W'(rd_ptr_nxt)];
                out_last <= (rd_ptr_nxt == rd_cnt - CNT_W'(1));
            end
            if (rd_finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign slot_available = (free_count != '0);

endmodule

// File: tb/tb_prt_slot_buffer.sv
// tb_prt_slot_buffer: self-checking bench for prt_slot_buffer (MAX_BEATS=8).
// Keeps a slot-level model (state per slot plus a queue of stored beats) and
// checks allocation, egress order, status outputs, overflow, abort and reject.

module tb_prt_slot_buffer;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int MB = 8;
    localparam int SW = 2;

    localparam int ST_FREE     = 0;
    localparam int ST_FILLING  = 1;
    localparam int ST_COMPLETE = 2;
    localparam int ST_SENDING  = 3;

    // Clock / reset and DUT signals
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_start = 1'b0;
    logic          wr_start_ack;
    logic [SW-1:0] wr_slot_id;
    logic          wr_abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          wr_done, wr_err;
    logic          rd_req = 1'b0;
    logic [SW-1:0] rd_slot = '0;
    logic          rd_ack, rd_rej;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [SW:0]   free_count;
    logic          slot_available;
    logic [NS-1:0] complete_mask;
`ifdef PRT_INVALIDATE_EN
    logic          inv_valid = 1'b0;
    logic [SW-1:0] inv_slot = '0;
    logic          inv_err;
`endif

    always #5 clk = ~clk;

    prt_slot_buffer #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_start(wr_start), .wr_start_ack(wr_start_ack), .wr_slot_id(wr_slot_id),
        .wr_abort(wr_abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .wr_done(wr_done), .wr_err(wr_err),
        .rd_req(rd_req), .rd_slot(rd_slot), .rd_ack(rd_ack), .rd_rej(rd_rej),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last),
`ifdef PRT_INVALIDATE_EN
        .inv_valid(inv_valid), .inv_slot(inv_slot), .inv_err(inv_err),
`endif
        .free_count(free_count), .slot_available(slot_available),
        .complete_mask(complete_mask)
    );

    // Scoreboard and model
    int            checks = 0;
    int            failures = 0;
    int            model_st [NS];
    logic [DW-1:0] slot_q [NS][$];
    logic [DW-1:0] exp_q [$];

    function automatic int model_lowest_free();
        for (int i = 0; i < NS; i++) if (model_st[i] == ST_FREE) return i;
        return -1;
    endfunction

    function automatic logic [SW:0] model_free_count();
        int n = 0;
        for (int i = 0; i < NS; i++) if (model_st[i] == ST_FREE) n++;
        return (SW + 1)'(n);
    endfunction

    function automatic logic [NS-1:0] model_complete_mask();
        logic [NS-1:0] m = '0;
        for (int i = 0; i < NS; i++) m[i] = (model_st[i] == ST_COMPLETE);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            model_st[i] = ST_FREE;
            slot_q[i].delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: allocate, stream n beats (last on beat n), check pulses and status
    task automatic write_frame(input int n, input bit directed, output int slot);
        int            exp_slot;
        bit            exp_err, exp_done;
        logic [DW-1:0] beats [$];
        exp_slot = model_lowest_free();
        slot = exp_slot;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        checks++;
        if (wr_start_ack !== 1'b1 || wr_slot_id !== SW'(exp_slot)) begin
            failures++;
            $display("FAIL alloc: ack=%b slot=%0d required ack=1 slot=%0d", wr_start_ack, wr_slot_id, exp_slot);
        end
        model_st[slot] = ST_FILLING;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            in_valid = 1'b1;
            in_data  = directed ? DW'(8'h11 + i) : DW'($urandom);
            in_last  = (i == n - 1);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL in_ready beat %0d: got %b required 1", i, in_ready);
            end
            if (i < MB) beats.push_back(in_data);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            exp_err  = (i == MB);
            exp_done = (i == n - 1) && (n <= MB);
            checks++;
            if (wr_err !== exp_err || wr_done !== exp_done) begin
                failures++;
                $display("FAIL write_pulses beat %0d: err=%b done=%b required err=%b done=%b",
                         i, wr_err, wr_done, exp_err, exp_done);
            end
        end
        if (n <= MB) begin
            model_st[slot] = ST_COMPLETE;
            slot_q[slot]   = beats;
        end else begin
            model_st[slot] = ST_FREE;
            slot_q[slot].delete();
        end
        checks++;
        if (free_count !== model_free_count() || complete_mask !== model_complete_mask()) begin
            failures++;
            $display("FAIL status_after_write: free=%0d mask=%b required free=%0d mask=%b",
                     free_count, complete_mask, model_free_count(), model_complete_mask());
        end
    endtask

    // Driver: request a slot; if accepted, drain it with toggling or random out_ready
    task automatic read_frame(input int slot, input bit toggle);
        bit exp_ok;
        bit rdy;
        int budget;
        exp_ok = (model_st[slot] == ST_COMPLETE);
        rd_req  = 1'b1;
        rd_slot = SW'(slot);
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_ack !== exp_ok || rd_rej !== !exp_ok) begin
            failures++;
            $display("FAIL rd_resp slot %0d: ack=%b rej=%b required ack=%b rej=%b",
                     slot, rd_ack, rd_rej, exp_ok, !exp_ok);
        end
        if (!exp_ok) return;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ack_cycle_valid: got %b required 0", out_valid);
        end
        model_st[slot] = ST_SENDING;
        exp_q = slot_q[slot];
        tick();
        budget = 0;
        rdy = 1'b0;
        while (exp_q.size() != 0 && budget < 200) begin
            rdy = toggle ? !rdy : 1'($urandom_range(0, 1));
            out_ready = rdy;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || out_last !== (exp_q.size() == 1)) begin
                failures++;
                $display("FAIL egress_beat: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                         out_valid, out_data, out_last, exp_q[0], exp_q.size() == 1);
            end
            if (out_valid === 1'b1 && rdy) void'(exp_q.pop_front());
            tick();
            budget++;
        end
        out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL egress_timeout: %0d beats left required 0", exp_q.size());
        end
        model_st[slot] = ST_FREE;
        slot_q[slot].delete();
        checks++;
        if (out_valid !== 1'b0 || free_count !== model_free_count() || complete_mask !== model_complete_mask()) begin
            failures++;
            $display("FAIL after_stream: valid=%b free=%0d mask=%b required valid=0 free=%0d mask=%b",
                     out_valid, free_count, complete_mask, model_free_count(), model_complete_mask());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (free_count !== 3'd4 || slot_available !== 1'b1 || complete_mask !== 4'b0000 ||
            wr_slot_id !== 2'd0 || out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_status: free=%0d avail=%b mask=%b slot=%0d data=%h required 4 1 0000 0 00",
                     free_count, slot_available, complete_mask, wr_slot_id, out_data);
        end
        checks++;
        if (wr_start_ack !== 1'b0 || wr_done !== 1'b0 || wr_err !== 1'b0 || rd_ack !== 1'b0 ||
            rd_rej !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses: ack=%b done=%b err=%b rack=%b rrej=%b rdy=%b ov=%b ol=%b required all 0",
                     wr_start_ack, wr_done, wr_err, rd_ack, rd_rej, in_ready, out_valid, out_last);
        end
    endtask

    task automatic test_write_read();
        int slot;
        write_frame(5, 1'b1, slot);
        checks++;
        if (slot != 0 || complete_mask !== 4'b0001 || free_count !== 3'd3) begin
            failures++;
            $display("FAIL first_frame: slot=%0d mask=%b free=%0d required 0 0001 3", slot, complete_mask, free_count);
        end
        read_frame(0, 1'b1);
        checks++;
        if (complete_mask !== 4'b0000 || free_count !== 3'd4) begin
            failures++;
            $display("FAIL after_first_read: mask=%b free=%0d required 0000 4", complete_mask, free_count);
        end
    endtask

    task automatic test_full_retry();
        int slot;
        for (int i = 0; i < NS; i++) write_frame($urandom_range(1, MB), 1'b0, slot);
        checks++;
        if (slot_available !== 1'b0 || free_count !== 3'd0) begin
            failures++;
            $display("FAIL full_status: avail=%b free=%0d required 0 0", slot_available, free_count);
        end
        wr_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (wr_start_ack !== 1'b0) begin
                failures++;
                $display("FAIL full_no_ack: got %b required 0", wr_start_ack);
            end
        end
        wr_start = 1'b0;
        read_frame(2, 1'b0);
        write_frame($urandom_range(1, MB), 1'b0, slot);
        checks++;
        if (slot != 2 || wr_slot_id !== 2'd2) begin
            failures++;
            $display("FAIL retry_slot: model=%0d dut=%0d required 2", slot, wr_slot_id);
        end
        read_frame(3, 1'b0);
        read_frame(0, 1'b1);
        read_frame(1, 1'b0);
        read_frame(2, 1'b0);
    endtask

    task automatic test_overflow();
        int slot;
        write_frame(10, 1'b1, slot);
        checks++;
        if (free_count !== 3'd4 || complete_mask !== 4'b0000) begin
            failures++;
            $display("FAIL overflow_freed: free=%0d mask=%b required 4 0000", free_count, complete_mask);
        end
        write_frame(MB + 1, 1'b0, slot);
        write_frame(MB, 1'b0, slot);
        read_frame(slot, 1'b0);
    endtask

    task automatic test_abort_reject();
        int slot;
        slot = model_lowest_free();
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        model_st[slot] = ST_FILLING;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        read_frame(slot, 1'b0);
        wr_abort = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_ready: got %b required 0", in_ready);
        end
        tick();
        wr_abort = 1'b0;
        in_valid = 1'b0;
        model_st[slot] = ST_FREE;
        checks++;
        if (free_count !== model_free_count() || wr_done !== 1'b0 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_freed: free=%0d done=%b err=%b required free=%0d done=0 err=0",
                     free_count, wr_done, wr_err, model_free_count());
        end
        read_frame(slot, 1'b0);
        write_frame(4, 1'b0, slot);
        read_frame(slot, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int slot;
        write_frame(3, 1'b0, slot);
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (free_count !== 3'd4 || complete_mask !== 4'b0000 || in_ready !== 1'b0 || wr_slot_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_frame: free=%0d mask=%b rdy=%b slot=%0d required 4 0000 0 0",
                     free_count, complete_mask, in_ready, wr_slot_id);
        end
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        read_frame(0, 1'b0);
    endtask

    task automatic test_random();
        int slot;
        for (int it = 0; it < 30; it++) begin
            if (model_lowest_free() >= 0 && $urandom_range(0, 2) != 0)
                write_frame($urandom_range(1, MB + 2), 1'b0, slot);
            else
                read_frame($urandom_range(0, NS - 1), 1'b0);
        end
        for (int i = 0; i < NS; i++) if (model_st[i] == ST_COMPLETE) read_frame(i, 1'b0);
    endtask

`ifdef PRT_INVALIDATE_EN
    task automatic test_invalidate();
        int slot;
        write_frame(3, 1'b0, slot);
        inv_valid = 1'b1;
        inv_slot  = SW'(slot);
        tick();
        inv_valid = 1'b0;
        model_st[slot] = ST_FREE;
        slot_q[slot].delete();
        checks++;
        if (inv_err !== 1'b0 || out_valid !== 1'b0 || free_count !== model_free_count() ||
            complete_mask !== model_complete_mask()) begin
            failures++;
            $display("FAIL inv_complete: err=%b ov=%b free=%0d mask=%b required 0 0 %0d %b",
                     inv_err, out_valid, free_count, complete_mask, model_free_count(), model_complete_mask());
        end
        inv_valid = 1'b1;
        inv_slot  = 2'd3;
        tick();
        inv_valid = 1'b0;
        checks++;
        if (inv_err !== 1'b1 || free_count !== model_free_count()) begin
            failures++;
            $display("FAIL inv_free: err=%b free=%0d required 1 %0d", inv_err, free_count, model_free_count());
        end
        write_frame(2, 1'b0, slot);
        inv_valid = 1'b1;
        inv_slot  = SW'(slot);
        rd_req    = 1'b1;
        rd_slot   = SW'(slot);
        tick();
        inv_valid = 1'b0;
        rd_req    = 1'b0;
        model_st[slot] = ST_FREE;
        slot_q[slot].delete();
        checks++;
        if (rd_rej !== 1'b1 || rd_ack !== 1'b0 || inv_err !== 1'b0 || free_count !== model_free_count()) begin
            failures++;
            $display("FAIL inv_vs_read: rej=%b ack=%b err=%b free=%0d required 1 0 0 %0d",
                     rd_rej, rd_ack, inv_err, free_count, model_free_count());
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL inv_no_egress: got %b required 0", out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_full_retry();
        test_overflow();
        test_abort_reject();
        test_reset_mid_frame();
        test_random();
`ifdef PRT_INVALIDATE_EN
        test_invalidate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
